// File: rtl/dmem_requester.sv
// Core-side requester for one byte-wide shared data memory port: word/byte reads, word writes.
// Optional DMEM_ALIGN_CHK_EN: rejects odd-address word accesses with resp_err instead of touching memory.
module dmem_requester #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic                    req_byte,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [2*DATA_WIDTH-1:0] resp_rdata,
`ifdef DMEM_ALIGN_CHK_EN
    output logic                    resp_err,
`endif
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [2*DATA_WIDTH-1:0] mem_w_data,
    output logic [ADDR_WIDTH-1:0]   mem_r_addr,
    input  logic [DATA_WIDTH-1:0]   mem_r_data
);

    localparam int unsigned WORD_WIDTH = 2 * DATA_WIDTH;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_LO  = 3'd1;
    localparam logic [2:0] RD_HI  = 3'd2;
    localparam logic [2:0] RD_CAP = 3'd3;
    localparam logic [2:0] WR     = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  byte_q,      byte_d;
    logic [DATA_WIDTH-1:0] lo_q,        lo_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [WORD_WIDTH-1:0] rdata_q,     rdata_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] w_addr_q,    w_addr_d;
    logic [WORD_WIDTH-1:0] w_data_q,    w_data_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,    r_addr_d;
`ifdef DMEM_ALIGN_CHK_EN
    logic                  err_q,       err_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            byte_q       <= 1'b0;
            lo_q         <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            mem_we_q     <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            r_addr_q     <= '0;
`ifdef DMEM_ALIGN_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_q       <= byte_d;
            lo_q         <= lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            mem_we_q     <= mem_we_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            r_addr_q     <= r_addr_d;
`ifdef DMEM_ALIGN_CHK_EN
            err_q        <= err_d;
`endif
        end
    end

    // Next-state and next-output logic; write port is zero outside WR
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        byte_d   = byte_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        mem_we_d = 1'b0;
        w_addr_d = '0;
        w_data_d = '0;
        r_addr_d = r_addr_q;
`ifdef DMEM_ALIGN_CHK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d = req_addr;
                    byte_d = req_byte & ~req_we;
`ifdef DMEM_ALIGN_CHK_EN
                    err_d  = 1'b0;
                    if ((req_we || !req_byte) && req_addr[0]) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else
`endif
                    if (req_we) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                        w_addr_d = req_addr;
                        w_data_d = req_wdata;
                    end else begin
                        state_d  = RD_LO;
                        r_addr_d = req_addr;
                    end
                end
            end
            RD_LO: begin
                state_d = RD_HI;
                if (!byte_q) begin
                    r_addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            RD_HI: begin
                if (byte_q) begin
                    state_d = RESP;
                    rdata_d = {DATA_WIDTH'(0), mem_r_data};
                end else begin
                    state_d = RD_CAP;
                    lo_d    = mem_r_data;
                end
            end
            RD_CAP: begin
                state_d = RESP;
                rdata_d = {mem_r_data, lo_q};
            end
            WR: begin
                state_d = RESP;
                rdata_d = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_w_addr = w_addr_q;
    assign mem_w_data = w_data_q;
    assign mem_r_addr = r_addr_q;
`ifdef DMEM_ALIGN_CHK_EN
    assign resp_err   = err_q;
`endif

endmodule
